ysyx_25040101_ifu: RTL

//  Instruction fetch unit: producer side of the instruction-decode interface. Holds the PC, issues
//  one 32-bit word read per instruction over a valid/ready memory bus, and presents the word plus
//  pre-split opcode/func3/func7 fields to the control unit. Next PC comes back from execute.

---
 rtl/ysyx_25040101_ifu.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ysyx_25040101_ifu.sv
// ysyx_25040101_ifu -- instruction fetch unit for a multi-cycle core.
//
// Holds the PC, fetches one 32-bit word per instruction over a valid/ready
// memory bus, and hands the word plus pre-split opcode/func3/func7 fields to
// decode. Execute returns the next PC. Exactly one instruction is in flight.
//
// Parameters:
//   RESET_PC  PC loaded on reset
//   TIMEOUT   WAIT cycles before a timeout fault (0 disables the watchdog)
//
// Optional feature macro: IFU_MISALIGN_CHK_EN
//   defined   : a misaligned next PC (or RESET_PC) raises fault_o and halts
//   undefined : next PC low two bits are forced to zero when loaded
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   halt_i                           stop fetching (sticky internally)
//   mem_req_valid_o/ready_i/addr_o   read request channel
//   mem_rsp_valid_i/data_i           read response (single-cycle pulse)
//   inst_valid_o/ready_i             instruction handshake to decode
//   inst_o, opcode_o, func3_o,
//   func7_o, pc_o                    instruction word, fields, its PC
//   npc_valid_i, npc_i               next PC from execute
//   fault_o                          sticky fault, forces HALT
module ysyx_25040101_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [15:0] TIMEOUT  = 16'd1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt_i,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_req_addr_o,
  input  logic        mem_rsp_valid_i,
  input  logic [31:0] mem_rsp_data_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [6:0]  opcode_o,
  output logic [2:0]  func3_o,
  output logic        func7_o,
  output logic [31:0] pc_o,
  input  logic        npc_valid_i,
  input  logic [31:0] npc_i,
  output logic        fault_o
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_EXEC,
    S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        halt_pend_q, halt_pend_d;
  logic        fault_q, fault_d;
  logic [15:0] wdog_q, wdog_d;
  logic        misalign_pc;

  // Watchdog saturates instead of wrapping so a disabled or huge TIMEOUT
  // never aliases back to a small count.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

`ifdef IFU_MISALIGN_CHK_EN
  assign misalign_pc = (pc_q[1:0] != 2'b00);
`else
  assign misalign_pc = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    inst_d          = inst_q;
    halt_pend_d     = halt_pend_q | halt_i;
    fault_d         = fault_q;
    wdog_d          = wdog_q;
    mem_req_valid_o = 1'b0;
    inst_valid_o    = 1'b0;

    case (state_q)
      S_FETCH: begin
        // Halt decisions are taken before a request goes out, so an accepted
        // request is always followed through to its response.
        if (halt_pend_q || fault_q || misalign_pc) begin
          if (misalign_pc) fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          mem_req_valid_o = 1'b1;
          if (mem_req_ready_i) begin
            wdog_d  = 16'd0;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid_i) begin
          inst_d  = mem_rsp_data_i;
          state_d = S_ISSUE;
        end else begin
          wdog_d = sat_inc16(wdog_q);
          if ((TIMEOUT != 16'd0) && (wdog_d == TIMEOUT)) begin
            fault_d = 1'b1;
            state_d = S_HALT;
          end
        end
      end
      S_ISSUE: begin
        inst_valid_o = 1'b1;
        if (inst_ready_i) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (npc_valid_i) begin
`ifdef IFU_MISALIGN_CHK_EN
          pc_d = npc_i;
          if (npc_i[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = S_HALT;
          end else begin
            state_d = S_FETCH;
          end
`else
          pc_d    = npc_i & ~32'h0000_0003;
          state_d = S_FETCH;
`endif
        end
      end
      default: begin
        state_d = S_HALT;
      end
    endcase

    // Reset is synchronous, so the state may still be anything during the
    // reset cycle; keep both valids low regardless.
    if (rst) begin
      mem_req_valid_o = 1'b0;
      inst_valid_o    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      inst_q      <= 32'h0000_0013;
      halt_pend_q <= 1'b0;
      fault_q     <= 1'b0;
      wdog_q      <= 16'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      halt_pend_q <= halt_pend_d;
      fault_q     <= fault_d;
      wdog_q      <= wdog_d;
    end
  end

  assign mem_req_addr_o = pc_q;
  assign pc_o           = pc_q;
  assign inst_o         = inst_q;
  assign opcode_o       = inst_q[6:0];
  assign func3_o        = inst_q[14:12];
  assign func7_o        = inst_q[30];
  assign fault_o        = fault_q;

endmodule
